// File: rtl/kyber_bram_packer_if.sv
// Coefficient stream, control and BRAM port B bundle for kyber_bram_packer.
// The slave modport is the packer side; master is the datapath/register side.
interface kyber_bram_packer_if #(
   parameter int COEF_W = 16,
   parameter int LANES  = 8,
   parameter int ADDR_W = 8
);
   logic                       start;
   logic [ADDR_W-1:0]          base_addr;
   logic [ADDR_W-1:0]          num_words;
   logic                       s_valid;
   logic [COEF_W-1:0]          s_data;
   logic                       s_ready;
   logic [ADDR_W-1:0]          addr_kb_br;
   logic                       en_kb_br;
   logic [COEF_W*LANES/8-1:0]  we_kb_br;
   logic [COEF_W*LANES-1:0]    wrdata_kb_br;
   logic                       busy;
   logic                       done;

   modport master (
      output start, base_addr, num_words, s_valid, s_data,
      input  s_ready, addr_kb_br, en_kb_br, we_kb_br, wrdata_kb_br,
      input  busy, done
   );

   modport slave (
      input  start, base_addr, num_words, s_valid, s_data,
      output s_ready, addr_kb_br, en_kb_br, we_kb_br, wrdata_kb_br,
      output busy, done
   );
endinterface

// File: rtl/kyber_bram_packer.sv
// Packs 16-bit Kyber coefficients eight per 128-bit word into BRAM port B.
// Define KYBER_PACKER_MODQ_EN to conditionally subtract q before storage.
module kyber_bram_packer #(
   parameter int COEF_W = 16,
   parameter int LANES  = 8,
   parameter int ADDR_W = 8
`ifdef KYBER_PACKER_MODQ_EN
   , parameter int KYBER_Q = 3329
`endif
) (
   input logic reg_clk,
   input logic reg_rst,
   kyber_bram_packer_if.slave bus
);
   localparam int DATA_W = COEF_W * LANES;
   localparam int LANE_W = $clog2(LANES);
   localparam int CNT_W  = ADDR_W + 1;

   typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

   state_t            state;
   state_t            state_nx;
   logic [LANE_W-1:0] lane_cnt;
   logic [CNT_W-1:0]  word_cnt;
   logic [CNT_W-1:0]  total;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] num;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] pack;
   logic [COEF_W-1:0] coef;
   logic              take;
   logic              last_lane;
   logic              last_word;

   assign take      = (state == FILL) && bus.s_valid;
   assign last_lane = lane_cnt == LANE_W'(LANES - 1);
   // A latched count of zero stands for a full 2**ADDR_W words
   assign total     = (num == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, num};
   assign last_word = (word_cnt + CNT_W'(1)) == total;

`ifdef KYBER_PACKER_MODQ_EN
   logic [12:0] low;
   logic        unused_hi;
   assign low       = bus.s_data[12:0];
   assign unused_hi = ^bus.s_data[COEF_W-1:13];
   assign coef      = COEF_W'((low >= 13'(KYBER_Q)) ? low - 13'(KYBER_Q) : low);
`else
   assign coef = bus.s_data;
`endif

   always_ff @(posedge reg_clk or posedge reg_rst) begin
      if (reg_rst) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.start) state_nx = FILL;
         FILL:    if (take && last_lane) state_nx = WRITE;
         WRITE:   state_nx = last_word ? DONE : FILL;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge reg_clk or posedge reg_rst) begin
      if (reg_rst) begin
         base     <= '0;
         num      <= '0;
         word_cnt <= '0;
         lane_cnt <= '0;
         addr     <= '0;
         pack     <= '0;
      end else begin
         if (state == IDLE && bus.start) begin
            base     <= bus.base_addr;
            num      <= bus.num_words;
            word_cnt <= '0;
            lane_cnt <= '0;
         end
         if (take) begin
            pack[lane_cnt*COEF_W +: COEF_W] <= coef;
            lane_cnt <= last_lane ? '0 : lane_cnt + LANE_W'(1);
            // Address is ready in the WRITE cycle itself; wraps mod 2**ADDR_W
            if (last_lane) addr <= base + word_cnt[ADDR_W-1:0];
         end
         if (state == WRITE) word_cnt <= word_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      bus.s_ready = state == FILL;
      bus.en_kb_br = state == WRITE;
      bus.we_kb_br = (state == WRITE) ? '1 : '0;
      bus.busy = state != IDLE;
      bus.done = state == DONE;
   end

   assign bus.addr_kb_br   = addr;
   assign bus.wrdata_kb_br = pack;

endmodule
